// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, requester limit
// and the width of the optional stall-timeout counter.
package uart_tx_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam int MAX_REQ  = 4;
    localparam int TO_CNT_W = 20;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above i_ptr, wrapping modulo N.
// Purely combinational; no state, no backpressure.
module rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N = 2
)(
    input  logic [MAX_REQ-1:0] i_req,
    input  logic [1:0]         i_ptr,
    output logic               o_found,
    output logic [1:0]         o_idx
);

    logic [1:0] w_cand;

    // Walk from the farthest offset down so the nearest candidate overwrites last.
    always_comb begin
        o_found = 1'b0;
        o_idx   = 2'd0;
        w_cand  = 2'd0;
        for (int k = N - 1; k >= 0; k--) begin
            w_cand = 2'((int'(i_ptr) + k) % N);
            if (i_req[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one UART TX byte port; 1-cycle grant latency, then
// combinational passthrough with out_ready->req_ready. Stall timeout built only with UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 65535
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [1:0]           grant_id,
    output logic                 busy,
    output logic                 timeout_pulse
);

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic [1:0]           r_grant_id;
    logic [1:0]           r_rr_ptr;
    logic [MAX_REQ-1:0]   w_valid_ext;
    logic [MAX_REQ-1:0]   w_last_ext;
    logic [8*MAX_REQ-1:0] w_data_ext;
    logic                 w_found;
    logic [1:0]           w_pick;
    logic                 w_own_vld;
    logic                 w_hs;
    logic                 w_done;
    logic                 w_expire;
    logic [1:0]           w_ptr_after;

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || TIMEOUT_CYCLES < 1 ||
        TIMEOUT_CYCLES >= (1 << TO_CNT_W)) begin : g_bad_cfg
        $error("uart_tx_arbiter: NUM_REQ or TIMEOUT_CYCLES out of range");
    end

    always_comb begin
        w_valid_ext                 = '0;
        w_last_ext                  = '0;
        w_data_ext                  = '0;
        w_valid_ext[NUM_REQ-1:0]    = req_valid;
        w_last_ext[NUM_REQ-1:0]     = req_last;
        w_data_ext[8*NUM_REQ-1:0]   = req_data;
    end

    rr_pick #(.N(NUM_REQ)) u_rr_pick (
        .i_req   (w_valid_ext),
        .i_ptr   (r_rr_ptr),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    assign w_own_vld   = w_valid_ext[r_grant_id];
    assign w_hs        = (r_state == ARB_BUSY) && w_own_vld && out_ready;
    assign w_done      = w_hs && w_last_ext[r_grant_id];
    assign w_ptr_after = (r_grant_id == 2'(NUM_REQ - 1)) ? 2'd0 : r_grant_id + 2'd1;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam logic [TO_CNT_W:0] TO_LIMIT = (TO_CNT_W + 1)'(TIMEOUT_CYCLES);

    logic [TO_CNT_W-1:0] r_to_cnt;
    logic                r_timeout_pulse;

    // Only owner-invalid cycles count; a valid owner blocked by out_ready is never revoked.
    assign w_expire = (r_state == ARB_BUSY) && !w_own_vld &&
                      (({1'b0, r_to_cnt} + (TO_CNT_W + 1)'(1)) == TO_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt        <= '0;
            r_timeout_pulse <= 1'b0;
        end else begin
            r_timeout_pulse <= w_expire && !w_done;
            if (r_state == ARB_IDLE || w_hs) begin
                r_to_cnt <= '0;
            end else if (!w_own_vld) begin
                r_to_cnt <= r_to_cnt + TO_CNT_W'(1);
            end
        end
    end

    assign timeout_pulse = r_timeout_pulse;
`else
    assign w_expire      = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ARB_IDLE;
            r_grant_id <= 2'd0;
            r_rr_ptr   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ARB_IDLE && w_found) begin
                r_grant_id <= w_pick;
            end
            if (w_done || w_expire) begin
                r_rr_ptr <= w_ptr_after;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: if (w_found)            w_state_nxt = ARB_BUSY;
            ARB_BUSY: if (w_done || w_expire) w_state_nxt = ARB_IDLE;
            default:                          w_state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = 8'd0;
        req_ready = '0;
        if (r_state == ARB_BUSY) begin
            out_valid = w_own_vld;
            out_data  = w_data_ext[{r_grant_id, 3'b000} +: 8];
            for (int i = 0; i < NUM_REQ; i++) begin
                req_ready[i] = (r_grant_id == 2'(i)) && out_ready;
            end
        end
    end

    assign busy     = (r_state == ARB_BUSY);
    assign grant_id = r_grant_id;

endmodule
